// File: rtl/shaper_peak_reader_pkg.sv
// Shared widths, reader defaults and the reader state encoding used by the
// trapezoidal filter back-end.
package shaper_peak_reader_pkg;

    localparam int SIZE_ADC_DATA = 14;
    // Filter output width; the reader consumes exactly this width.
    localparam int W_SAMPLE = SIZE_ADC_DATA + 6;

    localparam int READER_THRESHOLD = 100;
    localparam int READER_HYST      = 20;
    localparam int READER_SETTLE    = 4;
    localparam int READER_AVG_LOG2  = 2;
    localparam int READER_TS_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_ACCUM    = 3'd2,
        ST_REPORT   = 3'd3,
        ST_ABORT    = 3'd4,
        ST_WAIT_LOW = 3'd5
    } reader_state_e;

endpackage

// File: rtl/shaper_peak_reader_ts_counter.sv
// Free-running wrap-around timestamp counter, reusable by any timestamping block.
module shaper_peak_reader_ts_counter #(
    parameter int TS_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    output logic [TS_W-1:0] count_o
);

    logic [TS_W-1:0] count_q;
    logic [TS_W-1:0] count_d;

    assign count_d = en_i ? count_q + 1'b1 : count_q;
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/shaper_peak_reader.sv
// Detects trapezoids in the shaped stream, averages a flat-top window and
// emits one timestamped amplitude word (or a short-pulse flag) per pulse.
module shaper_peak_reader
    import shaper_peak_reader_pkg::*;
#(
    parameter int W         = W_SAMPLE,
    parameter int THRESHOLD = READER_THRESHOLD,
    parameter int HYST      = READER_HYST,
    parameter int SETTLE    = READER_SETTLE,
    parameter int AVG_LOG2  = READER_AVG_LOG2,
    parameter int TS_W      = READER_TS_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sample_en,
    input  logic [W-1:0]    sample,
    output logic [W-1:0]    amplitude,
    output logic            amp_valid,
    output logic [TS_W-1:0] timestamp,
    output logic            short_pulse,
    output logic            busy,
    output logic [2:0]      state_dbg
);

    localparam int AW = W + AVG_LOG2;
    localparam logic [7:0] SETTLE_LAST = 8'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [7:0] AVG_LAST    = 8'((1 << AVG_LOG2) - 1);

    reader_state_e          state_q;
    logic [7:0]             cnt_q;
    logic signed [AW-1:0]   acc_q;
    logic signed [AW-1:0]   acc_d;
    logic signed [AW-1:0]   acc_shr;
    logic [TS_W-1:0]        ts_q;
    logic [TS_W-1:0]        ts_count;
    logic [W-1:0]           amplitude_q;
    logic [TS_W-1:0]        timestamp_q;
    logic                   amp_valid_q;
    logic                   short_pulse_q;
    logic signed [W-1:0]    s;
    logic                   above;
    logic                   below_rearm;

    shaper_peak_reader_ts_counter #(.TS_W(TS_W)) u_ts (
        .clk     (clk),
        .rst_n   (reset),
        .en_i    (1'b1),
        .count_o (ts_count)
    );

    // All level compares are signed so negative samples can never trigger.
    assign s           = sample;
    assign above       = int'(s) > THRESHOLD;
    assign below_rearm = int'(s) < (THRESHOLD - HYST);
    assign acc_d       = acc_q + AW'(s);
    assign acc_shr     = acc_q >>> AVG_LOG2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            acc_q         <= '0;
            ts_q          <= '0;
            amplitude_q   <= '0;
            timestamp_q   <= '0;
            amp_valid_q   <= 1'b0;
            short_pulse_q <= 1'b0;
        end else begin
            amp_valid_q   <= 1'b0;
            short_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sample_en && above) begin
                        ts_q    <= ts_count;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        state_q <= (SETTLE == 0) ? ST_ACCUM : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (sample_en) begin
                        if (!above) begin
                            state_q <= ST_ABORT;
                        end else if (cnt_q == SETTLE_LAST) begin
                            cnt_q   <= '0;
                            acc_q   <= '0;
                            state_q <= ST_ACCUM;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (sample_en) begin
                        if (!above) begin
                            state_q <= ST_ABORT;
                        end else begin
                            acc_q <= acc_d;
                            if (cnt_q == AVG_LAST) begin
                                cnt_q   <= '0;
                                state_q <= ST_REPORT;
                            end else begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
                    end
                end
                ST_REPORT: begin
                    amplitude_q <= acc_shr[W-1:0];
                    timestamp_q <= ts_q;
                    amp_valid_q <= 1'b1;
                    state_q     <= ST_WAIT_LOW;
                end
                ST_ABORT: begin
                    short_pulse_q <= 1'b1;
                    state_q       <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (sample_en && below_rearm) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign amplitude   = amplitude_q;
    assign timestamp   = timestamp_q;
    assign amp_valid   = amp_valid_q;
    assign short_pulse = short_pulse_q;
    assign busy        = (state_q != ST_IDLE);
    assign state_dbg   = state_q;

endmodule
